dbus_bridge: RTL



---
 rtl/dbus_pkg.sv | 33 +++
 rtl/dbus_bridge_timer_counter.sv | 82 ++++++++
 rtl/dbus_bridge.sv | 63 ++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared address map, timer register layout and timer FSM encoding for the
// M-stage data-bus bridge.
package dbus_pkg;

  localparam logic [31:0] DEF_DM_LIMIT = 32'h0000_3000;
  localparam logic [31:0] DEF_TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEF_TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TC_WIN_LAST  = 32'h0000_000B;

  // Register index as seen on addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam logic [31:0] CTRL_MASK = 32'h0000_000B;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && (addr <= base + TC_WIN_LAST);
  endfunction

endpackage

// File: rtl/dbus_bridge_timer_counter.sv
// Countdown timer with CTRL/PRESET/COUNT registers and a sticky interrupt
// flag; one instance per timer window on the data bus.
module timer_counter
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state, state_nx;
  logic [31:0] ctrl, preset, count;
  logic        pending;
  logic        ctrl_we, preset_we, en_eff;

  assign ctrl_we   = we && (addr == TC_CTRL);
  assign preset_we = we && (addr == TC_PRESET);
  // An idle timer starts on the same edge as the enabling CTRL store, so the
  // load lands one edge later and COUNT shows PRESET after that edge.
  assign en_eff    = ctrl_we ? wdata[CTRL_EN] : ctrl[CTRL_EN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= TC_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      TC_IDLE: if (en_eff) state_nx = TC_LOAD;
      TC_LOAD: state_nx = TC_CNT;
      TC_CNT: begin
        if (!ctrl[CTRL_EN])       state_nx = TC_IDLE;
        else if (count <= 32'd1)  state_nx = TC_INT;
      end
      TC_INT:  state_nx = ctrl[CTRL_MODE] ? TC_LOAD : TC_IDLE;
      default: state_nx = TC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (state == TC_LOAD)
        count <= (preset == 32'd0) ? 32'd1 : preset;
      else if (state == TC_CNT && ctrl[CTRL_EN])
        count <= (count > 32'd1) ? count - 32'd1 : 32'd0;
      if (state == TC_CNT && ctrl[CTRL_EN] && count <= 32'd1)
        pending <= 1'b1;
      if (state == TC_INT && !ctrl[CTRL_MODE])
        ctrl[CTRL_EN] <= 1'b0;
      // Bus stores come last so a CTRL write beats the FSM's own EN clear.
      if (ctrl_we) begin
        ctrl    <= wdata & CTRL_MASK;
        pending <= 1'b0;
      end
      if (preset_we)
        preset <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      TC_CTRL:   rdata = ctrl;
      TC_PRESET: rdata = preset;
      TC_COUNT:  rdata = count;
      default:   rdata = '0;
    endcase
  end

  assign irq = pending && ctrl[CTRL_IM];

endmodule

// File: rtl/dbus_bridge.sv
// M-stage data-bus bridge: decodes the CPU address onto data memory or one of
// two countdown timers and returns load data combinationally.
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT = DEF_DM_LIMIT,
  parameter logic [31:0] TC0_BASE = DEF_TC0_BASE,
  parameter logic [31:0] TC1_BASE = DEF_TC1_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  irq
);

  logic        dm_hit, tc0_hit, tc1_hit, word_store;
  logic [31:0] tc0_rdata, tc1_rdata;

  assign dm_hit     = m_data_addr < DM_LIMIT;
  assign tc0_hit    = in_window(m_data_addr, TC0_BASE);
  assign tc1_hit    = in_window(m_data_addr, TC1_BASE);
  // Timers only accept full-word stores; partial stores are dropped.
  assign word_store = m_data_byteen == BE_WORD;

  assign dm_addr   = m_data_addr;
  assign dm_wdata  = m_data_wdata;
  assign dm_byteen = dm_hit ? m_data_byteen : 4'b0000;

  timer_counter u_tc0 (
    .clk   (clk),
    .reset (reset),
    .we    (tc0_hit && word_store),
    .addr  (m_data_addr[3:2]),
    .wdata (m_data_wdata),
    .rdata (tc0_rdata),
    .irq   (irq[0])
  );

  timer_counter u_tc1 (
    .clk   (clk),
    .reset (reset),
    .we    (tc1_hit && word_store),
    .addr  (m_data_addr[3:2]),
    .wdata (m_data_wdata),
    .rdata (tc1_rdata),
    .irq   (irq[1])
  );

  always_comb begin
    m_data_rdata = '0;
    if (dm_hit)       m_data_rdata = dm_rdata;
    else if (tc0_hit) m_data_rdata = tc0_rdata;
    else if (tc1_hit) m_data_rdata = tc1_rdata;
  end

endmodule
